// File: rtl/mem_stage_pkg.sv
// mem_stage shared decode constants and FSM state type.
// Imported by mem_align and mem_stage.
package mem_stage_pkg;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  localparam logic [6:0] INST_TYPE_L = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S = 7'b0100011;

  localparam logic [2:0] INST_LB  = 3'b000;
  localparam logic [2:0] INST_LH  = 3'b001;
  localparam logic [2:0] INST_LW  = 3'b010;
  localparam logic [2:0] INST_LBU = 3'b100;
  localparam logic [2:0] INST_LHU = 3'b101;
  localparam logic [2:0] INST_SB  = 3'b000;
  localparam logic [2:0] INST_SH  = 3'b001;
  localparam logic [2:0] INST_SW  = 3'b010;

  localparam logic [4:0] X0 = 5'd0;

endpackage

// File: rtl/mem_align.sv
// Store lane/strobe placement and load extract/extension by func3, addr[1:0].
// MEM_MISALIGN_TRAP_EN: flag misaligned halfword/word accesses.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  func3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] rdata_o,
  output logic        f3_ok_o,
  output logic        misal_o
);

  logic       f_b, f_h, f_w, f_u;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign f_b = func3_i[1:0] == INST_LB[1:0];
  assign f_h = func3_i[1:0] == INST_LH[1:0];
  assign f_w = func3_i[1:0] == INST_LW[1:0];
  assign f_u = func3_i[2];

  // Loads allow unsigned B/H only; stores have no unsigned forms.
  assign f3_ok_o = is_store_i ? (~f_u & (f_b | f_h | f_w))
                              : (f_b | f_h | (f_w & ~f_u));

  assign byte_v = rdata_i[{off_i, 3'b000} +: 8];
  assign half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misal_o = (f_h & off_i[0]) | (f_w & (|off_i));
`else
  assign misal_o = 1'b0;
`endif

  always_comb begin
    wdata_o = '0;
    wstrb_o = '0;
    rdata_o = '0;
    unique case (1'b1)
      f_b: begin
        wdata_o = {4{wdata_i[7:0]}};
        wstrb_o = 4'b0001 << off_i;
        rdata_o = {{24{~f_u & byte_v[7]}}, byte_v};
      end
      f_h: begin
        wdata_o = {2{wdata_i[15:0]}};
        wstrb_o = off_i[1] ? 4'b1100 : 4'b0011;
        rdata_o = {{16{~f_u & half_v[15]}}, half_v};
      end
      f_w: begin
        wdata_o = wdata_i;
        wstrb_o = 4'b1111;
        rdata_o = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: writeback register plus single-outstanding load/store.
// MEM_MISALIGN_TRAP_EN (in mem_align) traps misaligned accesses on err_o.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] ins_i,
  input  logic [31:0] ins_addr_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  input  logic        rd_wr_en_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_wr_en_o,
  output logic [31:0] ins_addr_o,
  output logic        hold_flag_o,
  output logic        err_o
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_e      state_q;
  logic [CW-1:0] cnt_q;
  logic        req_q, we_q, rd_we_q, err_q, is_st_q;
  logic [31:0] addr_q, wdata_q, rd_data_q, ins_addr_q;
  logic [3:0]  wstrb_q;
  logic [4:0]  rd_addr_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        is_ld, is_st, is_mem, busy, timeout_hit;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic        al_st, al_ok, al_misal;
  logic [31:0] al_wdata, al_rdata;
  logic [3:0]  al_wstrb;
  logic        unused_ins;

  assign unused_ins = ^{ins_i[31:15], ins_i[11:7]};

  assign busy   = state_q == S_BUSY;
  assign is_ld  = ins_i[6:0] == INST_TYPE_L;
  assign is_st  = ins_i[6:0] == INST_TYPE_S;
  assign is_mem = (is_ld | is_st) & al_ok;

  // Captured access drives the aligner while BUSY for the load extract.
  assign al_f3  = busy ? f3_q    : ins_i[14:12];
  assign al_off = busy ? off_q   : mem_addr_i[1:0];
  assign al_st  = busy ? is_st_q : is_st;

  mem_align u_align (
    .is_store_i (al_st),
    .func3_i    (al_f3),
    .off_i      (al_off),
    .wdata_i    (mem_wdata_i),
    .rdata_i    (mem_rdata_i),
    .wdata_o    (al_wdata),
    .wstrb_o    (al_wstrb),
    .rdata_o    (al_rdata),
    .f3_ok_o    (al_ok),
    .misal_o    (al_misal)
  );

  if (TIMEOUT_CYC == 0) begin : g_no_to
    assign timeout_hit = 1'b0;
  end else begin : g_to
    assign timeout_hit = cnt_q == CW'(TIMEOUT_CYC - 1);
  end

  always_comb begin
    hold_flag_o = 1'b0;
    if (busy) hold_flag_o = ~(mem_ack_i | timeout_hit);
    else      hold_flag_o = valid_i & is_mem & ~al_misal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_we_q    <= 1'b0;
      ins_addr_q <= '0;
      err_q      <= 1'b0;
      is_st_q    <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          rd_we_q <= 1'b0;
          if (valid_i) begin
            ins_addr_q <= ins_addr_i;
            rd_addr_q  <= rd_addr_i;
            rd_data_q  <= rd_data_i;
            if (!is_mem) begin
              rd_we_q <= rd_wr_en_i & ~(is_ld | is_st);
            end else if (al_misal) begin
              err_q <= 1'b1;
            end else begin
              state_q <= S_BUSY;
              cnt_q   <= '0;
              req_q   <= 1'b1;
              we_q    <= is_st;
              addr_q  <= {mem_addr_i[31:2], 2'b00};
              wdata_q <= is_st ? al_wdata : '0;
              wstrb_q <= is_st ? al_wstrb : 4'b0000;
              is_st_q <= is_st;
              f3_q    <= ins_i[14:12];
              off_q   <= mem_addr_i[1:0];
            end
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_ack_i) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            rd_we_q <= ~is_st_q;
            if (!is_st_q) rd_data_q <= al_rdata;
          end else if (timeout_hit) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_data_o   = rd_data_q;
  assign rd_wr_en_o  = rd_we_q;
  assign ins_addr_o  = ins_addr_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a writeback scoreboard queue.
// Default build; MEM_MISALIGN_TRAP_EN selects the trapping SW case.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] ins_i, ins_addr_i, rd_data_i;
  logic [4:0]  rd_addr_i;
  logic        rd_wr_en_i;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_i;
  logic        mem_ack_i;
  logic        mem_req_o, mem_we_o, rd_wr_en_o, hold_flag_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, rd_data_o, ins_addr_o;
  logic [3:0]  mem_wstrb_o;
  logic [4:0]  rd_addr_o;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .ins_i       (ins_i),
    .ins_addr_i  (ins_addr_i),
    .rd_addr_i   (rd_addr_i),
    .rd_data_i   (rd_data_i),
    .rd_wr_en_i  (rd_wr_en_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wstrb_o (mem_wstrb_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .rd_addr_o   (rd_addr_o),
    .rd_data_o   (rd_data_o),
    .rd_wr_en_o  (rd_wr_en_o),
    .ins_addr_o  (ins_addr_o),
    .hold_flag_o (hold_flag_o),
    .err_o       (err_o)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic        en;
  } wb_t;

  wb_t exp_q[$];
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag);
    wb_t e;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_we"}, rd_wr_en_o, e.en);
    if (e.en) begin
      chk({tag, "_rd"}, rd_addr_o, e.a);
      chk({tag, "_data"}, rd_data_o, e.d);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op,
                                     input logic [2:0] f3);
    return {17'd0, f3, 5'd0, op};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd);
    valid_i     = 1'b1;
    ins_i       = ins;
    ins_addr_i  = 32'h0000_4000 + addr;
    mem_addr_i  = addr;
    mem_wdata_i = wd;
    rd_addr_i   = rd;
    rd_data_i   = 32'hDEAD_0000;
    rd_wr_en_i  = 1'b1;
  endtask

  // Accept at T, ack at T+dly+1, return at T+dly+2 (writeback cycle).
  task automatic run_mem(input logic [31:0] ins, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input int dly, input logic [31:0] rdata,
                         output int holds, output int reqs, output int bwb,
                         output logic [31:0] baddr, output logic [31:0] bwd,
                         output logic [3:0] bst, output logic bwe);
    holds = 0; reqs = 0; bwb = 0;
    baddr = '0; bwd = '0; bst = '0; bwe = 1'b0;
    drive(ins, addr, wd, rd);
    @(negedge clk);
    if (hold_flag_o) holds++;
    for (int c = 1; c <= dly + 1; c++) begin
      cyc();
      if (mem_req_o) reqs++;
      if (rd_wr_en_o) bwb++;
      if (c == 1) begin
        baddr = mem_addr_o; bwd = mem_wdata_o;
        bst = mem_wstrb_o; bwe = mem_we_o;
      end
      if (c == dly + 1) begin
        mem_ack_i = 1'b1;
        mem_rdata_i = rdata;
      end
      @(negedge clk);
      if (hold_flag_o) holds++;
    end
    cyc();
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    valid_i = 1'b0;
  endtask

  int holds, reqs, bwb;
  logic [31:0] baddr, bwd;
  logic [3:0]  bst;
  logic        bwe;

  initial begin
    rst = 1'b1; valid_i = 1'b0; ins_i = '0; ins_addr_i = '0;
    rd_addr_i = '0; rd_data_i = '0; rd_wr_en_i = 1'b0;
    mem_addr_i = '0; mem_wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    repeat (3) cyc();
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_wstrb", mem_wstrb_o, 0);
    chk("rst_rd", {rd_addr_o, rd_wr_en_o}, 0);
    chk("rst_rdd", rd_data_o, 0);
    chk("rst_pc", ins_addr_o, 0);
    chk("rst_err", err_o, 0);
    rst = 1'b0;
    cyc();

    // ADDI passthrough
    drive(mk(7'b0010011, 3'b000), 32'h0, 32'h0, 5'd5);
    rd_data_i = 32'h1234;
    exp_q.push_back('{a: 5'd5, d: 32'h1234, en: 1'b1});
    @(negedge clk);
    chk("addi_hold", hold_flag_o, 0);
    cyc();
    valid_i = 1'b0;
    chk_wb("addi");
    chk("addi_pc", ins_addr_o, 32'h4000);
    cyc();
    chk("idle_we", rd_wr_en_o, 0);

    // LB 0x103, ack three cycles after request
    exp_q.push_back('{a: 5'd7, d: 32'hFFFF_FF80, en: 1'b1});
    run_mem(mk(INST_TYPE_L, INST_LB), 32'h103, 0, 5'd7, 3, 32'h80FF_0000,
            holds, reqs, bwb, baddr, bwd, bst, bwe);
    chk("lb_addr", baddr, 32'h100);
    chk("lb_holds", holds, 4);
    chk("lb_reqs", reqs, 4);
    chk("lb_busy_wb", bwb, 0);
    chk("lb_req_lo", mem_req_o, 0);
    chk_wb("lb");
    chk("lb_pc", ins_addr_o, 32'h4103);

    // LHU 0x102, ack in the first request cycle
    exp_q.push_back('{a: 5'd9, d: 32'h0000_BEEF, en: 1'b1});
    run_mem(mk(INST_TYPE_L, INST_LHU), 32'h102, 0, 5'd9, 0, 32'hBEEF_1234,
            holds, reqs, bwb, baddr, bwd, bst, bwe);
    chk("lhu_holds", holds, 1);
    chk("lhu_reqs", reqs, 1);
    chk_wb("lhu");

    // SB 0x201
    exp_q.push_back('{a: 5'd3, d: 32'h0, en: 1'b0});
    run_mem(mk(INST_TYPE_S, INST_SB), 32'h201, 32'hAABB_CCDD, 5'd3, 1, 0,
            holds, reqs, bwb, baddr, bwd, bst, bwe);
    chk("sb_strb", bst, 4'b0010);
    chk("sb_wdata", bwd, 32'hDDDD_DDDD);
    chk("sb_we", bwe, 1);
    chk("sb_addr", baddr, 32'h200);
    chk_wb("sb");

    // SH upper half
    exp_q.push_back('{a: 5'd3, d: 32'h0, en: 1'b0});
    run_mem(mk(INST_TYPE_S, INST_SH), 32'h206, 32'h1122_3344, 5'd3, 0, 0,
            holds, reqs, bwb, baddr, bwd, bst, bwe);
    chk("sh_strb", bst, 4'b1100);
    chk("sh_wdata", bwd, 32'h3344_3344);
    chk_wb("sh");

    // LH sign extension, lower half
    exp_q.push_back('{a: 5'd4, d: 32'hFFFF_8001, en: 1'b1});
    run_mem(mk(INST_TYPE_L, INST_LH), 32'h400, 0, 5'd4, 2, 32'h7FFF_8001,
            holds, reqs, bwb, baddr, bwd, bst, bwe);
    chk("lh_we", bwe, 0);
    chk_wb("lh");

    // LW with ack in the last allowed cycle beats the timeout
    exp_q.push_back('{a: 5'd11, d: 32'hCAFE_F00D, en: 1'b1});
    run_mem(mk(INST_TYPE_L, INST_LW), 32'h500, 0, 5'd11, TO - 1,
            32'hCAFE_F00D, holds, reqs, bwb, baddr, bwd, bst, bwe);
    chk("lw_edge_reqs", reqs, TO);
    chk("lw_edge_holds", holds, TO);
    chk("lw_edge_err", err_o, 0);
    chk_wb("lw_edge");

    // Ack while idle is ignored
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h5555_5555;
    cyc();
    mem_ack_i = 1'b0;
    chk("idle_ack_req", mem_req_o, 0);
    chk("idle_ack_we", rd_wr_en_o, 0);

    // Unknown func3 on a load
    drive(mk(INST_TYPE_L, 3'b011), 32'h600, 0, 5'd12);
    exp_q.push_back('{a: 5'd12, d: 32'h0, en: 1'b0});
    @(negedge clk);
    chk("bad_f3_hold", hold_flag_o, 0);
    cyc();
    valid_i = 1'b0;
    chk("bad_f3_req", mem_req_o, 0);
    chk_wb("bad_f3");

    // LW with no ack: timeout
    drive(mk(INST_TYPE_L, INST_LW), 32'h700, 0, 5'd13);
    holds = 0; reqs = 0;
    @(negedge clk);
    if (hold_flag_o) holds++;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (!mem_req_o) break;
      reqs++;
      @(negedge clk);
      if (hold_flag_o) holds++;
    end
    valid_i = 1'b0;
    exp_q.push_back('{a: 5'd13, d: 32'h0, en: 1'b0});
    chk("to_reqs", reqs, TO);
    chk("to_holds", holds, TO);
    chk("to_err", err_o, 1);
    chk_wb("to");
    cyc();
    chk("to_err_pulse", err_o, 0);

    // Reset in the middle of a wait
    drive(mk(INST_TYPE_L, INST_LW), 32'h800, 0, 5'd14);
    repeat (5) cyc();
    chk("mid_req_hi", mem_req_o, 1);
    rst = 1'b1;
    valid_i = 1'b0;
    cyc();
    chk("mid_rst_req", mem_req_o, 0);
    chk("mid_rst_err", err_o, 0);
    rst = 1'b0;
    cyc();
    chk("mid_rst_idle", mem_req_o, 0);

    // SW 0x302
`ifdef MEM_MISALIGN_TRAP_EN
    drive(mk(INST_TYPE_S, INST_SW), 32'h302, 32'h0BAD_BEEF, 5'd1);
    exp_q.push_back('{a: 5'd1, d: 32'h0, en: 1'b0});
    @(negedge clk);
    chk("sw_mis_hold", hold_flag_o, 0);
    cyc();
    valid_i = 1'b0;
    chk("sw_mis_req", mem_req_o, 0);
    chk("sw_mis_err", err_o, 1);
    chk_wb("sw_mis");
`else
    exp_q.push_back('{a: 5'd1, d: 32'h0, en: 1'b0});
    run_mem(mk(INST_TYPE_S, INST_SW), 32'h302, 32'h0BAD_BEEF, 5'd1, 0, 0,
            holds, reqs, bwb, baddr, bwd, bst, bwe);
    chk("sw_addr", baddr, 32'h300);
    chk("sw_strb", bst, 4'b1111);
    chk("sw_wdata", bwd, 32'h0BAD_BEEF);
    chk("sw_err", err_o, 0);
    chk_wb("sw");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
